// File: rtl/ppu_bus_pkg.sv
// ppu_bus_pkg: shared PPU register-port definitions and the OAM DMA state encoding.
package ppu_bus_pkg;

    typedef enum logic [2:0] {
        CONTROL = 3'd0,
        MASK,
        STATUS,
        OAMADDR,
        OAMDATA,
        SCROLL,
        ADDR,
        DATA
    } ppu_reg_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE,
        S_DONE
    } dma_state_e;

    localparam logic PPU_CS_ACTIVE = 1'b0;
    localparam logic PPU_RW_WRITE  = 1'b0;

endpackage

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: halts the CPU and copies one 256-byte CPU page into PPU OAMDATA.
module oam_dma_controller
    import ppu_bus_pkg::*;
#(
    parameter int          OAM_BYTES    = 256,
    parameter logic [2:0]  OAM_DATA_IDX = 3'(OAMDATA)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmaStart,
    input  logic [7:0]  dmaPage,
    input  logic        cpuOddCycle,
    output logic [15:0] memAddr,
    output logic        memRead,
    input  logic [7:0]  memData,
    output logic        cpuHalt,
    output logic [2:0]  ppuAddr,
    output logic        ppuCs,
    output logic        ppuRw,
    output logic [7:0]  ppuData,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST = 8'(OAM_BYTES - 1);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] count_q, count_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            page_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        count_d = count_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (dmaStart) begin
                    state_d = S_HALT;
                    page_d  = dmaPage;
                    count_d = '0;
                end
            end
            S_HALT:  state_d = cpuOddCycle ? S_ALIGN : S_READ;
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                state_d = S_WRITE;
                data_d  = memData;
            end
            S_WRITE: begin
                state_d = (count_q == LAST) ? S_DONE : S_READ;
                count_d = (count_q == LAST) ? count_q : count_q + 8'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Low address byte is the counter alone, so page 0xFF never carries into the high byte.
    assign memRead = (state_q == S_READ);
    assign memAddr = memRead ? {page_q, count_q} : 16'h0000;
    assign ppuCs   = (state_q == S_WRITE) ? PPU_CS_ACTIVE : ~PPU_CS_ACTIVE;
    assign ppuRw   = (state_q == S_WRITE) ? PPU_RW_WRITE : ~PPU_RW_WRITE;
    assign ppuAddr = OAM_DATA_IDX;
    assign ppuData = data_q;
    assign busy    = (state_q == S_HALT) || (state_q == S_ALIGN) ||
                     (state_q == S_READ) || (state_q == S_WRITE);
    assign cpuHalt = busy;
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller: table-driven transfer scenarios plus reset and back-to-back sequences.
module tb_oam_dma_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dmaStart = 1'b0;
    logic [7:0]  dmaPage = 8'h00;
    logic        cpuOddCycle = 1'b0;
    logic [15:0] memAddr;
    logic        memRead;
    logic [7:0]  memData;
    logic        cpuHalt;
    logic [2:0]  ppuAddr;
    logic        ppuCs;
    logic        ppuRw;
    logic [7:0]  ppuData;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    oam_dma_controller dut (
        .clk(clk), .reset(reset), .dmaStart(dmaStart), .dmaPage(dmaPage),
        .cpuOddCycle(cpuOddCycle), .memAddr(memAddr), .memRead(memRead),
        .memData(memData), .cpuHalt(cpuHalt), .ppuAddr(ppuAddr), .ppuCs(ppuCs),
        .ppuRw(ppuRw), .ppuData(ppuData), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory image: page 0x02 holds i^0xA5; other pages are further xored with (page-2).
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'hA5 ^ (a[15:8] - 8'h02);
    endfunction

    always_comb memData = memRead ? mem_byte(memAddr) : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] page;
        logic       odd;
        bit         inj;
        int         exp_busy;
        int         exp_first;
        int         exp_done;
    } vec_t;

    // Called at a negedge; dmaStart is sampled at the next posedge (edge 0).
    task automatic run_dma(input vec_t v, input string tag);
        int busy_n = 0, wr_n = 0, rd_n = 0, bad = 0, first_rd = -1;
        int done_n = 0, done_cyc = -1, foreign = 0;
        logic [15:0] first_a = '0, last_a = '0;
        logic idle_busy = 1'b1, idle_read = 1'b1;
        bit fin = 0;
        dmaPage  = v.page;
        dmaStart = 1'b1;
        for (int cyc = 1; cyc <= 700 && !fin; cyc++) begin
            @(negedge clk);
            dmaStart    = 1'b0;
            dmaPage     = 8'h5A;
            cpuOddCycle = (cyc % 2 == 1) ? v.odd : !v.odd;
            if (busy) busy_n++;
            if (memRead) begin
                if (first_rd < 0) begin
                    first_rd = cyc;
                    first_a  = memAddr;
                end
                last_a = memAddr;
                if (memAddr[15:8] != v.page) foreign++;
                if (memAddr != {v.page, 8'(rd_n)}) bad++;
                rd_n++;
            end
            if (!ppuCs) begin
                if (ppuRw !== 1'b0 || ppuAddr !== 3'd4 || ppuData !== mem_byte({v.page, 8'(wr_n)})) begin
                    if (bad == 0)
                        $display("FAIL %s write %0d: got 0x%0h expected 0x%0h", tag, wr_n, ppuData,
                                 mem_byte({v.page, 8'(wr_n)}));
                    bad++;
                end
                wr_n++;
            end else if (!ppuRw) bad++;
            if (done) begin
                done_n++;
                done_cyc = cyc;
                if (v.inj) begin
                    dmaStart = 1'b1;
                    dmaPage  = 8'h07;
                end
            end else if (done_cyc > 0) begin
                fin       = 1;
                idle_busy = busy;
                idle_read = memRead;
            end
            if (v.inj && cyc == 100) begin
                dmaStart = 1'b1;
                dmaPage  = 8'h07;
            end
        end
        chk({tag, " finished"}, 32'(fin), 32'd1);
        chk({tag, " busy cycles"}, busy_n, v.exp_busy);
        chk({tag, " reads"}, rd_n, 256);
        chk({tag, " ppu writes"}, wr_n, 256);
        chk({tag, " data/addr errors"}, bad, 0);
        chk({tag, " first read cycle"}, first_rd, v.exp_first);
        chk({tag, " first addr"}, 32'(first_a), 32'({v.page, 8'h00}));
        chk({tag, " last addr"}, 32'(last_a), 32'({v.page, 8'hFF}));
        chk({tag, " foreign page reads"}, foreign, 0);
        chk({tag, " done pulses"}, done_n, 1);
        chk({tag, " done cycle"}, done_cyc, v.exp_done);
        chk({tag, " idle busy"}, 32'(idle_busy), 32'd0);
        chk({tag, " idle read"}, 32'(idle_read), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int done_seen;
        vecs[0] = '{page: 8'h02, odd: 1'b0, inj: 0, exp_busy: 513, exp_first: 2, exp_done: 514};
        vecs[1] = '{page: 8'h02, odd: 1'b1, inj: 0, exp_busy: 514, exp_first: 3, exp_done: 515};
        vecs[2] = '{page: 8'hFF, odd: 1'b0, inj: 0, exp_busy: 513, exp_first: 2, exp_done: 514};
        vecs[3] = '{page: 8'h02, odd: 1'b0, inj: 1, exp_busy: 513, exp_first: 2, exp_done: 514};
        vecs[4] = '{page: 8'h03, odd: 1'b1, inj: 0, exp_busy: 514, exp_first: 3, exp_done: 515};

        repeat (3) @(negedge clk);
        chk("reset memAddr", 32'(memAddr), 32'h0);
        chk("reset memRead", 32'(memRead), 32'h0);
        chk("reset cpuHalt", 32'(cpuHalt), 32'h0);
        chk("reset ppuAddr", 32'(ppuAddr), 32'h4);
        chk("reset ppuCs", 32'(ppuCs), 32'h1);
        chk("reset ppuRw", 32'(ppuRw), 32'h1);
        chk("reset ppuData", 32'(ppuData), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Each entry starts in the first IDLE cycle after the previous done.
        foreach (vecs[i]) run_dma(vecs[i], $sformatf("vec%0d", i));

        // Reset during the WRITE of byte 100 (cycle 203 with even parity).
        dmaPage  = 8'h02;
        dmaStart = 1'b1;
        for (int cyc = 1; cyc <= 203; cyc++) begin
            @(negedge clk);
            dmaStart    = 1'b0;
            cpuOddCycle = 1'b0;
        end
        chk("byte100 ppuCs", 32'(ppuCs), 32'h0);
        chk("byte100 ppuData", 32'(ppuData), 32'(8'd100 ^ 8'hA5));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post-reset ppuCs", 32'(ppuCs), 32'h1);
        chk("post-reset ppuRw", 32'(ppuRw), 32'h1);
        chk("post-reset cpuHalt", 32'(cpuHalt), 32'h0);
        chk("post-reset busy", 32'(busy), 32'h0);
        chk("post-reset memRead", 32'(memRead), 32'h0);
        chk("post-reset ppuData", 32'(ppuData), 32'h0);
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (done || busy) done_seen++;
            @(negedge clk);
        end
        chk("post-reset quiet", done_seen, 0);
        run_dma(vecs[0], "after-reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

CPU-side initiator for the PPU register port. On a CPU write to $4014 it halts the CPU, reads 256 bytes from CPU address page `dmaPage`, and writes each byte into the PPU OAM data register (index 4) using the same active-low chip-select and read/write protocol that the PPU register decoder answers. It sits between the CPU memory bus and the PPU register port, alongside the CPU core's RDY/halt logic.

## Interface
Parameters:
- `OAM_BYTES`, 256: bytes transferred per DMA. The counter is 8 bits and the transfer ends on wrap from 255.
- `OAM_DATA_IDX`, 3'd4: PPU register index driven on `ppuAddr`.

Ports:
- `clk` in 1: system clock, one CPU cycle per edge.
- `reset` in 1: synchronous, active-high.
- `dmaStart` in 1: one-cycle pulse. Indicates a CPU write to $4014.
- `dmaPage` in 8: source page, sampled when `dmaStart` is accepted.
- `cpuOddCycle` in 1: CPU cycle parity, 1 = odd cycle.
- `memAddr` out 16: CPU-bus read address.
- `memRead` out 1: read strobe.
- `memData` in 8: read data. Valid and sampled at the clock edge that ends a READ cycle.
- `cpuHalt` out 1: holds the CPU off the bus.
- `ppuAddr` out 3: PPU register index. Constant `OAM_DATA_IDX`.
- `ppuCs` out 1: PPU chip select, active-low.
- `ppuRw` out 1: 0 = write to the PPU, 1 = read/idle.
- `ppuData` out 8: byte being written to the PPU.
- `busy` out 1: high from HALT through the last WRITE.
- `done` out 1: one-cycle pulse after the final write.

## Operation
States: IDLE, HALT, ALIGN, READ, WRITE, DONE. Outputs are a Moore decode of the state plus registers.

Transitions:
- IDLE → HALT on `dmaStart`. Latch `dmaPage` into `pageReg`, clear the 8-bit `count`.
- HALT → ALIGN if `cpuOddCycle`=1, otherwise HALT → READ.
- ALIGN → READ.
- READ → WRITE. Latch `memData` into `dataReg`.
- WRITE → READ with `count`+1 when `count`≠255. WRITE → DONE when `count`=255.
- DONE → IDLE.

Output behaviour by state:
- READ: `memAddr`={`pageReg`,`count`}, `memRead`=1.
- WRITE: `ppuCs`=0, `ppuRw`=0, `ppuData`=`dataReg`. In every other state `ppuCs`=1, `ppuRw`=1.
- HALT, ALIGN, READ, WRITE: `cpuHalt`=1, `busy`=1.
- DONE: `cpuHalt`=0, `busy`=0, `done`=1.

Boundary conditions:
- `dmaStart` outside IDLE is ignored, including in DONE. The page is not re-latched.
- Address low byte comes only from `count`. Page 0xFF reads 0xFF00–0xFFFF with no carry into the high byte.
- `reset` in any state forces IDLE on the next edge. Outputs return to reset values at once and no partial-byte write is emitted.
- Reset values: `memAddr`=0, `memRead`=0, `cpuHalt`=0, `ppuAddr`=4, `ppuCs`=1, `ppuRw`=1, `ppuData`=0, `busy`=0, `done`=0, `pageReg`=0, `count`=0, `dataReg`=0.

## Timing
- Edge 0 samples `dmaStart`. HALT is active in cycle 1.
- Busy length is 513 cycles with even parity and 514 with odd parity: 1 HALT + 0/1 ALIGN + 256×(READ, WRITE).
- Byte i is read in cycle 2+a+2i and written in cycle 3+a+2i, where a = 1 if ALIGN was taken, else 0.
- `done` is high in cycle 514+a. The controller accepts a new `dmaStart` from cycle 515+a.
- `cpuOddCycle` is sampled only in HALT.
- `ppuData` is stable for the whole WRITE cycle. It holds its last value outside WRITE and is not a don't-care.

## Structure
- Shared package `ppu_bus_pkg`:
  - enum `ppu_reg_e` (CONTROL=0, MASK, STATUS, OAMADDR, OAMDATA, SCROLL, ADDR, DATA=7), reused by the PPU register decoder;
  - enum `dma_state_e`;
  - constants `PPU_CS_ACTIVE`=0 and `PPU_RW_WRITE`=0.
- Single module, no sub-modules. The counter and data latch are inline.

## Test plan
- Page 0x02, `cpuOddCycle`=0, memory[0x0200+i]=i^0xA5:
  - `busy` high exactly 513 cycles;
  - exactly 256 cycles with `ppuCs`=0/`ppuRw`=0/`ppuAddr`=4;
  - byte i = i^0xA5, in order;
  - `done` pulses once.
- Page 0x02, `cpuOddCycle`=1 at HALT → one ALIGN cycle, 514 busy cycles, first READ in cycle 3.
- Page 0xFF → `memAddr` runs 0xFF00..0xFFFF, then `memRead` drops. No read of 0x0000.
- `dmaStart` with page 0x07 pulsed at cycle 100 of a page-0x02 transfer and again in the DONE cycle → both ignored. All addresses stay 0x02xx.
- `reset` asserted during the WRITE of byte 100 → next cycle IDLE, `ppuCs`=1, `cpuHalt`=0, `busy`=0, no `done` pulse. A new start after reset begins at byte 0.
- Back-to-back: `dmaStart` (page 0x03) in the first IDLE cycle after `done` → accepted. A full second transfer completes with correct data.
